// File: rtl/nlfsr_feedback_selector_if.sv
// Bundle between the NLFSR feedback selector and its driver/NLFSR side.
// The master drives start/ena/state/flags. The slave (the selector) returns feedback, status and taps.
interface nlfsr_feedback_selector_if #(
  parameter int SIZE  = 16,
  parameter int TAP_W = $clog2(SIZE)
);
  logic             start;
  logic             ena;
  logic [SIZE-1:0]  state;
  logic             found;
  logic             failure;
  logic             feedback;
  logic             selector_done;
  logic             nlfsr_res;
  logic             busy;
  logic             all_done;
  logic             hit_valid;
  logic             hit;
  logic [TAP_W-1:0] tap_a;
  logic [TAP_W-1:0] tap_b;
  logic [TAP_W-1:0] tap_c;
  logic [TAP_W-1:0] tap_d;

  modport master (
    output start, ena, state, found, failure,
    input  feedback, selector_done, nlfsr_res, busy, all_done, hit_valid, hit,
           tap_a, tap_b, tap_c, tap_d
  );

  modport slave (
    input  start, ena, state, found, failure,
    output feedback, selector_done, nlfsr_res, busy, all_done, hit_valid, hit,
           tap_a, tap_b, tap_c, tap_d
  );
endinterface

// File: rtl/nlfsr_feedback_selector.sv
// Sweeps NLFSR feedback candidates fb = s[a]^s[b]^(s[c]&s[d]) and reports one verdict per valid candidate.
// Optional macro STOP_ON_HIT_EN: the first full-period hit ends the sweep with taps/hit held.
module nlfsr_feedback_selector #(
  parameter int SIZE  = 16,
  parameter int TAP_W = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       res,
  nlfsr_feedback_selector_if.slave   bus
);

  localparam int CW = 4 * TAP_W;
  localparam logic [TAP_W:0] SIZE_LIM = (TAP_W + 1)'(SIZE);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              cand_reg, cand_next;
  logic [3:0][TAP_W-1:0]      tap_reg, tap_next;
  logic                       hit_reg, hit_next;
  logic [3:0][TAP_W-1:0]      cand_tap;
  logic [3:0]                 tap_in_range;
  logic                       cand_valid;
  logic                       cand_last;
  logic                       verdict;
  logic                       nlfsr_res_int;

  // Element 0 is tap a (counter MSBs), element 3 is tap d (counter LSBs).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      assign cand_tap[gi]     = cand_reg[CW-1-gi*TAP_W -: TAP_W];
      assign tap_in_range[gi] = {1'b0, cand_tap[gi]} < SIZE_LIM;
    end
  endgenerate

  assign cand_valid = (&tap_in_range) && (cand_tap[0] < cand_tap[1]) && (cand_tap[2] < cand_tap[3]);
  assign cand_last  = &cand_reg;
  assign verdict    = (state_reg == RUN) && bus.ena && (bus.found || bus.failure);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= IDLE;
      cand_reg  <= '0;
      tap_reg   <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      tap_reg   <= tap_next;
      hit_reg   <= hit_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    tap_next      = tap_reg;
    hit_next      = hit_reg;
    nlfsr_res_int = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = LOAD;
          cand_next  = '0;
        end
      end
      LOAD: begin
        if (cand_valid) begin
          tap_next      = cand_tap;
          nlfsr_res_int = 1'b1;
          state_next    = RUN;
        end else if (cand_last) begin
          state_next = DONE;
        end else begin
          cand_next = cand_reg + CW'(1);
        end
      end
      RUN: begin
        if (verdict) begin
          // found wins when both flags arrive together
          hit_next = bus.found;
`ifdef STOP_ON_HIT_EN
          state_next = bus.found ? DONE : NEXT;
`else
          state_next = NEXT;
`endif
        end
      end
      NEXT: begin
        if (cand_last) begin
          state_next = DONE;
        end else begin
          cand_next  = cand_reg + CW'(1);
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.feedback      = (state_reg == RUN) &&
                             ((bus.state[tap_reg[0]] ^ bus.state[tap_reg[1]]) ^
                              (bus.state[tap_reg[2]] & bus.state[tap_reg[3]]));
  assign bus.selector_done = (state_reg == RUN);
  assign bus.nlfsr_res     = nlfsr_res_int;
  assign bus.busy          = (state_reg == LOAD) || (state_reg == RUN) || (state_reg == NEXT);
  assign bus.all_done      = (state_reg == DONE);
  assign bus.hit_valid     = verdict;
  // The verdict is visible in its pulse cycle and held afterwards.
  assign bus.hit           = verdict ? bus.found : hit_reg;
  assign bus.tap_a         = tap_reg[0];
  assign bus.tap_b         = tap_reg[1];
  assign bus.tap_c         = tap_reg[2];
  assign bus.tap_d         = tap_reg[3];

endmodule

// File: tb/tb_nlfsr_feedback_selector.sv
// Directed bench for nlfsr_feedback_selector (SIZE=4) with a verdict scoreboard.
module tb_nlfsr_feedback_selector;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic [1:0] d;
    logic       hit;
  } verdict_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   checks = 0;
  int   failures = 0;
  verdict_t   sb[$];
  logic [7:0] exp_taps[$];

  always #5 clk = ~clk;

  nlfsr_feedback_selector_if #(.SIZE(4)) dut_if ();

  nlfsr_feedback_selector #(.SIZE(4)) dut (
    .clk (clk),
    .res (res),
    .bus (dut_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {dut_if.feedback, dut_if.selector_done, dut_if.nlfsr_res, dut_if.busy,
            dut_if.all_done, dut_if.hit_valid, dut_if.hit,
            dut_if.tap_a, dut_if.tap_b, dut_if.tap_c, dut_if.tap_d};
  endfunction

  function automatic logic [7:0] cur_taps();
    return {dut_if.tap_a, dut_if.tap_b, dut_if.tap_c, dut_if.tap_d};
  endfunction

  // Acts as the NLFSR: raises found (candidate hit_idx) or failure three cycles into each RUN.
  task automatic run_sweep(input int hit_idx, input int max_pulses, output int pulses);
    int run_cnt;
    int k;
    verdict_t got;
    verdict_t want;
    run_cnt = 0;
    k = 0;
    pulses = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dut_if.all_done || pulses >= max_pulses) break;
      if (dut_if.selector_done) begin
        run_cnt++;
        if (run_cnt == 3) begin
          if (k >= exp_taps.size()) begin
            chk("extra_candidate", k, exp_taps.size());
          end else begin
            if (k == hit_idx) dut_if.found = 1'b1;
            else              dut_if.failure = 1'b1;
            sb.push_back({exp_taps[k], (k == hit_idx)});
          end
          k++;
        end
      end else begin
        run_cnt = 0;
        dut_if.found = 1'b0;
        dut_if.failure = 1'b0;
      end
      #1;
      if (dut_if.hit_valid) begin
        got = {cur_taps(), dut_if.hit};
        if (sb.size() == 0) begin
          chk("unexpected_verdict", 1, 0);
        end else begin
          want = sb.pop_front();
          $display("verdict %0d taps=%02h hit=%0b expected taps=%02h hit=%0b",
                   pulses, got[8:1], got.hit, want[8:1], want.hit);
          chk("verdict", got, want);
        end
        pulses++;
      end
      step();
    end
    dut_if.found = 1'b0;
    dut_if.failure = 1'b0;
  endtask

  initial begin
    int n;
    int hv;
    int pulses;
    verdict_t got;
    verdict_t want;

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++)
            if (a < b && c < d) exp_taps.push_back(8'(a * 64 + b * 16 + c * 4 + d));

    dut_if.start = 1'b0;
    dut_if.ena = 1'b1;
    dut_if.state = '0;
    dut_if.found = 1'b0;
    dut_if.failure = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_outputs", all_outs(), 15'd0);
    res = 1'b1;
    step();
    chk("idle_outputs", all_outs(), 15'd0);

    // Sweep start: invalid candidates 0x00..0x10 skipped silently
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    chk("busy_after_start", dut_if.busy, 1'b1);
    n = 0;
    hv = 0;
    while (!dut_if.nlfsr_res && n < 300) begin
      if (dut_if.hit_valid) hv++;
      step();
      n++;
    end
    $display("first nlfsr_res after %0d load cycles", n);
    chk("first_load_cycles", n, 17);
    chk("no_verdict_invalid", hv, 0);
    step();
    chk("run_selector_done", dut_if.selector_done, 1'b1);
    chk("first_taps", cur_taps(), 8'h11);

    // Feedback with taps (0,1,0,1)
    dut_if.state = 4'b0011; #1 chk("fb_0011", dut_if.feedback, 1'b1);
    dut_if.state = 4'b0001; #1 chk("fb_0001", dut_if.feedback, 1'b1);
    dut_if.state = 4'b0010; #1 chk("fb_0010", dut_if.feedback, 1'b1);
    dut_if.state = 4'b0000; #1 chk("fb_0000", dut_if.feedback, 1'b0);
    dut_if.state = 4'b1100; #1 chk("fb_1100", dut_if.feedback, 1'b0);

    // Both flags with ena=0: ignored, stay in RUN
    dut_if.ena = 1'b0;
    dut_if.found = 1'b1;
    dut_if.failure = 1'b1;
    #1 chk("ena0_no_pulse", dut_if.hit_valid, 1'b0);
    step();
    chk("ena0_hold_run", dut_if.selector_done, 1'b1);
    chk("ena0_no_pulse2", dut_if.hit_valid, 1'b0);

    // Both flags with ena=1: one pulse, found wins
    dut_if.ena = 1'b1;
    sb.push_back({exp_taps[0], 1'b1});
    #1;
    chk("both_flags_pulse", dut_if.hit_valid, 1'b1);
    got = {cur_taps(), dut_if.hit};
    want = sb.pop_front();
    $display("verdict both-flags taps=%02h hit=%0b", got[8:1], got.hit);
    chk("both_flags_verdict", got, want);
    step();
    dut_if.found = 1'b0;
    dut_if.failure = 1'b0;
    #1;
    chk("pulse_one_cycle", dut_if.hit_valid, 1'b0);
    chk("hit_held", dut_if.hit, 1'b1);
    chk("next_not_run", dut_if.selector_done, 1'b0);

    // Reset in the middle of the next RUN
    n = 0;
    while (!dut_if.selector_done && n < 100) begin
      step();
      n++;
    end
    chk("reach_second_run", dut_if.selector_done, 1'b1);
    res = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 15'd0);
    step();
    chk("reset_next_cycle", all_outs(), 15'd0);
    res = 1'b1;
    step();

    // Full sweep, every candidate fails
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    run_sweep(-1, 1000, pulses);
    chk("sweep_pulses", pulses, 36);
    chk("sweep_all_done", dut_if.all_done, 1'b1);
    chk("sweep_not_busy", dut_if.busy, 1'b0);
    chk("sweep_hit_held0", dut_if.hit, 1'b0);
    chk("sweep_sb_empty", sb.size(), 0);
    step();
    chk("done_held", dut_if.all_done, 1'b1);

    // Restart from DONE, found on the third valid candidate
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    chk("restart_clears_done", dut_if.all_done, 1'b0);
    chk("restart_busy", dut_if.busy, 1'b1);
    run_sweep(2, 3, pulses);
    chk("hit_sweep_pulses", pulses, 3);
`ifdef STOP_ON_HIT_EN
    chk("stop_all_done", dut_if.all_done, 1'b1);
    chk("stop_not_busy", dut_if.busy, 1'b0);
    chk("stop_taps", cur_taps(), exp_taps[2]);
    chk("stop_hit", dut_if.hit, 1'b1);
    step();
    chk("stop_held", {dut_if.all_done, dut_if.hit, cur_taps()}, {2'b11, exp_taps[2]});
`else
    chk("continue_busy", dut_if.busy, 1'b1);
    chk("continue_not_done", dut_if.all_done, 1'b0);
    chk("continue_hit_held", dut_if.hit, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
